// File: rtl/vc_head_flit_buffer_pkg.sv
// Shared types and helpers for the per-VC head flit buffer and the switch-side
// logic that reuses its arbiter.
package vc_head_flit_buffer_pkg;

  function automatic int vc_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    ASSEMBLING = 2'd1,
    REQUEST    = 2'd2
  } slot_state_t;

endpackage

// File: rtl/vc_head_flit_buffer_if.sv
// Phit intake and route-reserve request bundle between an input port and the switch.
interface vc_head_flit_buffer_if
  import vc_head_flit_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int REQUEST_WIDTH = 2,
  parameter int NUM_VC        = 2
);
  localparam int VC_W = vc_width(NUM_VC);

  logic                     phit_valid;
  logic [VC_W-1:0]          phit_vc;
  logic [DATA_WIDTH-1:0]    phit_data;
  logic [NUM_VC-1:0]        head_ready;
  logic                     req_valid;
  logic [VC_W-1:0]          req_vc;
  logic [REQUEST_WIDTH-1:0] req_route;
  logic                     req_grant;
  logic [NUM_VC-1:0]        route_reserved;
  logic                     overflow_err;

  modport master (
    output phit_valid, phit_vc, phit_data, req_grant,
    input  head_ready, req_valid, req_vc, req_route, route_reserved, overflow_err
  );

  modport slave (
    input  phit_valid, phit_vc, phit_data, req_grant,
    output head_ready, req_valid, req_vc, req_route, route_reserved, overflow_err
  );
endinterface

// File: rtl/vc_head_flit_buffer_decoder.sv
// Head flit route decoder: destination is the header value modulo N, compared
// against this node's index (0 = local, 1 = higher node, 2 = lower node).
module HeadFlitDecoder #(
  parameter int N             = 4,
  parameter int INDEX         = 1,
  parameter int FLIT_WIDTH    = 16,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic [FLIT_WIDTH-1:0]    head_flit,
  output logic [REQUEST_WIDTH-1:0] route
);

  logic [FLIT_WIDTH-1:0] dest;

  assign dest = head_flit % FLIT_WIDTH'(N);

  always_comb begin
    if (dest == FLIT_WIDTH'(INDEX))
      route = REQUEST_WIDTH'(0);
    else if (dest > FLIT_WIDTH'(INDEX))
      route = REQUEST_WIDTH'(1);
    else
      route = REQUEST_WIDTH'(2);
  end

endmodule

// File: rtl/vc_head_flit_buffer_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr, wrapping.
module rr_arbiter
  import vc_head_flit_buffer_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = vc_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // First pass scans slots at or above ptr, second pass the wrapped-around ones.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < NUM_REQ; c++) begin
        if (!found && req[c] && ((pass == 0) == (c >= int'(ptr)))) begin
          found    = 1'b1;
          grant[c] = 1'b1;
          idx      = IDX_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/vc_head_flit_buffer.sv
// Per-VC head flit assembly with a single round-robin route-reserve request port.
module vc_head_flit_buffer
  import vc_head_flit_buffer_pkg::*;
#(
  parameter int N             = 4,
  parameter int INDEX         = 1,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int REQUEST_WIDTH = 2,
  parameter int NUM_VC        = 2
) (
  input logic                  clk,
  input logic                  rst,
  vc_head_flit_buffer_if.slave bus
);

  localparam int VC_W       = vc_width(NUM_VC);
  localparam int CNT_W      = vc_width(PhitPerFlit);
  localparam int FLIT_WIDTH = DATA_WIDTH * PhitPerFlit;

  slot_state_t           state  [NUM_VC];
  logic [CNT_W-1:0]      cnt    [NUM_VC];
  logic [FLIT_WIDTH-1:0] buffer [NUM_VC];

  logic [VC_W-1:0]   rr_ptr, locked_vc, sel_vc, arb_idx;
  logic              lock, arb_found, handshake;
  logic [NUM_VC-1:0] requesting, phit_hit, arb_grant, sel_onehot;

  always_comb begin
    requesting = '0;
    phit_hit   = '0;
    sel_onehot = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      requesting[v] = (state[v] == REQUEST);
      phit_hit[v]   = bus.phit_valid && (bus.phit_vc == VC_W'(v));
      sel_onehot[v] = lock ? (locked_vc == VC_W'(v)) : arb_grant[v];
    end
  end

  assign bus.head_ready = ~requesting;
  assign sel_vc         = lock ? locked_vc : arb_idx;
  assign bus.req_valid  = lock | arb_found;
  assign bus.req_vc     = sel_vc;
  assign handshake      = bus.req_valid & bus.req_grant;

  rr_arbiter #(.NUM_REQ(NUM_VC)) u_arb (
    .req   (requesting),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  HeadFlitDecoder #(
    .N             (N),
    .INDEX         (INDEX),
    .FLIT_WIDTH    (FLIT_WIDTH),
    .REQUEST_WIDTH (REQUEST_WIDTH)
  ) u_decoder (
    .head_flit (buffer[sel_vc]),
    .route     (bus.req_route)
  );

  // Granted slots free up; others accept phits only when not holding a complete head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state[v]  <= EMPTY;
        cnt[v]    <= '0;
        buffer[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (handshake && sel_onehot[v]) begin
          state[v] <= EMPTY;
        end else if (phit_hit[v] && !requesting[v]) begin
          for (int p = 0; p < PhitPerFlit; p++) begin
            if (cnt[v] == CNT_W'(p))
              buffer[v][p*DATA_WIDTH +: DATA_WIDTH] <= bus.phit_data;
          end
          if (cnt[v] == CNT_W'(PhitPerFlit - 1)) begin
            cnt[v]   <= '0;
            state[v] <= REQUEST;
          end else begin
            cnt[v]   <= cnt[v] + 1'b1;
            state[v] <= ASSEMBLING;
          end
        end
      end
    end
  end

  // An unanswered request is frozen so req_vc/req_route stay put until the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr             <= '0;
      lock               <= 1'b0;
      locked_vc          <= '0;
      bus.route_reserved <= '0;
      bus.overflow_err   <= 1'b0;
    end else begin
      bus.route_reserved <= handshake ? sel_onehot : '0;
      if (handshake) begin
        lock   <= 1'b0;
        rr_ptr <= (sel_vc == VC_W'(NUM_VC - 1)) ? '0 : sel_vc + 1'b1;
      end else if (bus.req_valid) begin
        lock      <= 1'b1;
        locked_vc <= sel_vc;
      end
      if (|(phit_hit & requesting))
        bus.overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_head_flit_buffer.sv
// Directed scenarios plus randomized traffic for vc_head_flit_buffer, checked
// against a queue-level model of waiting heads and the offered request.
module tb_vc_head_flit_buffer;

  localparam int DW = 8;
  localparam int RW = 2;
  localparam int NV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  vc_head_flit_buffer_if #(.DATA_WIDTH(DW), .REQUEST_WIDTH(RW), .NUM_VC(NV)) bus ();

  vc_head_flit_buffer #(
    .N(4), .INDEX(1), .DATA_WIDTH(DW), .PhitPerFlit(2), .REQUEST_WIDTH(RW), .NUM_VC(NV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Model: collected phits per VC, heads waiting for the switch, and the
  // request currently offered (held until granted; -1 when none).
  logic [15:0] m_buf     [NV];
  int          m_cnt     [NV];
  bit          m_waiting [NV];
  int          m_ptr;
  int          m_cur;
  logic [1:0]  m_pulse;
  bit          m_ovf;

  bit         e_valid;
  int         e_vc;
  logic [1:0] e_route;
  logic [1:0] e_ready;

  function automatic logic [1:0] route_of(input logic [15:0] flit);
    int dest;
    dest = int'(flit % 16'd4);
    if (dest == 1) return 2'd0;
    if (dest > 1)  return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_buf[v] = '0;
      m_cnt[v] = 0;
      m_waiting[v] = 1'b0;
    end
    m_ptr = 0;
    m_cur = -1;
    m_pulse = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_outputs();
    e_ready = '0;
    for (int v = 0; v < NV; v++) e_ready[v] = !m_waiting[v];
    e_vc = m_cur;
    if (e_vc < 0) begin
      for (int k = 0; k < NV; k++) begin
        int c;
        c = (m_ptr + k) % NV;
        if (e_vc < 0 && m_waiting[c]) e_vc = c;
      end
    end
    e_valid = (e_vc >= 0);
    e_route = e_valid ? route_of(m_buf[e_vc]) : 2'd0;
  endtask

  task automatic model_step();
    bit pre_wait [NV];
    int v;
    model_outputs();
    pre_wait = m_waiting;
    m_pulse = '0;
    if (e_valid && bus.req_grant) begin
      m_waiting[e_vc] = 1'b0;
      m_pulse[e_vc] = 1'b1;
      m_ptr = (e_vc + 1) % NV;
      m_cur = -1;
    end else if (e_valid) begin
      m_cur = e_vc;
    end
    if (bus.phit_valid) begin
      v = int'(bus.phit_vc);
      if (pre_wait[v]) begin
        m_ovf = 1'b1;
      end else begin
        m_buf[v][8*m_cnt[v] +: 8] = bus.phit_data;
        m_cnt[v]++;
        if (m_cnt[v] == 2) begin
          m_cnt[v] = 0;
          m_waiting[v] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    @(negedge clk);
  endtask

  task automatic send_phit(input int vc, input logic [7:0] data);
    bus.phit_valid = 1'b1;
    bus.phit_vc    = 1'(vc);
    bus.phit_data  = data;
    tick();
    bus.phit_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.phit_valid = 1'b0;
    bus.req_grant  = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++; if (bus.head_ready !== 2'b11) begin errors++; $display("[TB] FAIL reset_head_ready got=%b exp=11", bus.head_ready); end
    checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got=%b exp=0", bus.req_valid); end
    checks++; if (bus.req_vc !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_vc got=%b exp=0", bus.req_vc); end
    checks++; if (bus.route_reserved !== 2'b00) begin errors++; $display("[TB] FAIL reset_route_reserved got=%b exp=00", bus.route_reserved); end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", bus.overflow_err); end
    @(negedge clk);
    rst = 1'b1;
    send_phit(1, 8'h55);
    bus.req_grant = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_async_valid got=%b exp=0", bus.req_valid); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (bus.route_reserved !== 2'b00) begin errors++; $display("[TB] FAIL reset_no_pulse got=%b exp=00", bus.route_reserved); end
    bus.req_grant = 1'b0;
    send_phit(1, 8'h02);
    checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_early_valid got=%b exp=0", bus.req_valid); end
    send_phit(1, 8'h03);
    checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_valid_after got=%b exp=1", bus.req_valid); end
    checks++; if (bus.req_vc !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_vc_after got=%b exp=1", bus.req_vc); end
    checks++; if (bus.req_route !== 2'd1) begin errors++; $display("[TB] FAIL reset_req_route got=%0d exp=1", bus.req_route); end
    checks++; if (dut.buffer[1] !== 16'h0302) begin errors++; $display("[TB] FAIL reset_buffer1 got=%h exp=0302", dut.buffer[1]); end
    checks++; if (bus.route_reserved !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulse_after got=%b exp=00", bus.route_reserved); end
  endtask

  task automatic test_basic_handshake();
    do_reset();
    send_phit(0, 8'h01);
    send_phit(0, 8'h02);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid cycle=%0d got=%b exp=1", i, bus.req_valid); end
      checks++; if (bus.req_vc !== 1'b0) begin errors++; $display("[TB] FAIL basic_vc cycle=%0d got=%b exp=0", i, bus.req_vc); end
      checks++; if (bus.req_route !== 2'd0) begin errors++; $display("[TB] FAIL basic_route cycle=%0d got=%0d exp=0", i, bus.req_route); end
      checks++; if (bus.head_ready !== 2'b10) begin errors++; $display("[TB] FAIL basic_ready cycle=%0d got=%b exp=10", i, bus.head_ready); end
      if (i == 3) bus.req_grant = 1'b1;
      tick();
    end
    bus.req_grant = 1'b0;
    checks++; if (bus.route_reserved !== 2'b01) begin errors++; $display("[TB] FAIL basic_pulse got=%b exp=01", bus.route_reserved); end
    checks++; if (bus.head_ready !== 2'b11) begin errors++; $display("[TB] FAIL basic_ready_after got=%b exp=11", bus.head_ready); end
    checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_after got=%b exp=0", bus.req_valid); end
    tick();
    checks++; if (bus.route_reserved !== 2'b00) begin errors++; $display("[TB] FAIL basic_pulse_width got=%b exp=00", bus.route_reserved); end
  endtask

  task automatic test_round_robin();
    do_reset();
    send_phit(0, 8'h10);
    send_phit(1, 8'h23);
    send_phit(0, 8'h12);
    send_phit(1, 8'h22);
    checks++; if (bus.head_ready !== 2'b00) begin errors++; $display("[TB] FAIL rr_ready got=%b exp=00", bus.head_ready); end
    checks++; if (bus.req_vc !== 1'b0) begin errors++; $display("[TB] FAIL rr_first_vc got=%b exp=0", bus.req_vc); end
    checks++; if (bus.req_route !== 2'd2) begin errors++; $display("[TB] FAIL rr_first_route got=%0d exp=2", bus.req_route); end
    bus.req_grant = 1'b1;
    tick();
    checks++; if (bus.route_reserved !== 2'b01) begin errors++; $display("[TB] FAIL rr_pulse0 got=%b exp=01", bus.route_reserved); end
    checks++; if (bus.req_vc !== 1'b1 || bus.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_second_vc got=%b/%b exp=1/1", bus.req_vc, bus.req_valid); end
    checks++; if (bus.req_route !== 2'd1) begin errors++; $display("[TB] FAIL rr_second_route got=%0d exp=1", bus.req_route); end
    tick();
    checks++; if (bus.route_reserved !== 2'b10) begin errors++; $display("[TB] FAIL rr_pulse1 got=%b exp=10", bus.route_reserved); end
    checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_drained got=%b exp=0", bus.req_valid); end
    send_phit(0, 8'h40);
    send_phit(1, 8'h50);
    send_phit(0, 8'h41);
    checks++; if (bus.req_vc !== 1'b0 || bus.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_refill_vc0 got=%b/%b exp=0/1", bus.req_vc, bus.req_valid); end
    send_phit(1, 8'h51);
    checks++; if (bus.route_reserved !== 2'b01) begin errors++; $display("[TB] FAIL rr_refill_pulse0 got=%b exp=01", bus.route_reserved); end
    checks++; if (bus.req_vc !== 1'b1 || bus.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_refill_vc1 got=%b/%b exp=1/1", bus.req_vc, bus.req_valid); end
    tick();
    checks++; if (bus.route_reserved !== 2'b10) begin errors++; $display("[TB] FAIL rr_refill_pulse1 got=%b exp=10", bus.route_reserved); end
    bus.req_grant = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    send_phit(1, 8'h31);
    send_phit(1, 8'h32);
    checks++; if (bus.req_vc !== 1'b1 || bus.req_route !== 2'd0) begin errors++; $display("[TB] FAIL lock_initial got=%b/%0d exp=1/0", bus.req_vc, bus.req_route); end
    send_phit(0, 8'h40);
    send_phit(0, 8'h41);
    tick();
    checks++; if (bus.head_ready !== 2'b00) begin errors++; $display("[TB] FAIL lock_ready got=%b exp=00", bus.head_ready); end
    checks++; if (bus.req_vc !== 1'b1) begin errors++; $display("[TB] FAIL lock_hold_vc got=%b exp=1", bus.req_vc); end
    checks++; if (bus.req_route !== 2'd0) begin errors++; $display("[TB] FAIL lock_hold_route got=%0d exp=0", bus.req_route); end
    bus.req_grant = 1'b1;
    tick();
    checks++; if (bus.route_reserved !== 2'b10) begin errors++; $display("[TB] FAIL lock_pulse1 got=%b exp=10", bus.route_reserved); end
    checks++; if (bus.req_vc !== 1'b0 || bus.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL lock_next_vc got=%b/%b exp=0/1", bus.req_vc, bus.req_valid); end
    checks++; if (bus.req_route !== 2'd2) begin errors++; $display("[TB] FAIL lock_next_route got=%0d exp=2", bus.req_route); end
    tick();
    checks++; if (bus.route_reserved !== 2'b01) begin errors++; $display("[TB] FAIL lock_pulse0 got=%b exp=01", bus.route_reserved); end
    bus.req_grant = 1'b0;
  endtask

  task automatic test_interleave();
    do_reset();
    send_phit(0, 8'hA0);
    send_phit(1, 8'hB0);
    send_phit(0, 8'hA1);
    send_phit(1, 8'hB1);
    checks++; if (dut.buffer[0] !== 16'hA1A0) begin errors++; $display("[TB] FAIL inter_buffer0 got=%h exp=A1A0", dut.buffer[0]); end
    checks++; if (dut.buffer[1] !== 16'hB1B0) begin errors++; $display("[TB] FAIL inter_buffer1 got=%h exp=B1B0", dut.buffer[1]); end
    checks++; if (bus.head_ready !== 2'b00) begin errors++; $display("[TB] FAIL inter_ready got=%b exp=00", bus.head_ready); end
    checks++; if (bus.req_valid !== 1'b1 || bus.req_vc !== 1'b0) begin errors++; $display("[TB] FAIL inter_req got=%b/%b exp=1/0", bus.req_valid, bus.req_vc); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_phit(0, 8'h05);
    send_phit(0, 8'h06);
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got=%b exp=0", bus.overflow_err); end
    send_phit(0, 8'h77);
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got=%b exp=1", bus.overflow_err); end
    checks++; if (dut.buffer[0] !== 16'h0605) begin errors++; $display("[TB] FAIL ovf_buffer got=%h exp=0605", dut.buffer[0]); end
    bus.req_grant = 1'b1;
    send_phit(0, 8'h88);
    bus.req_grant = 1'b0;
    checks++; if (dut.buffer[0] !== 16'h0605) begin errors++; $display("[TB] FAIL ovf_grant_buffer got=%h exp=0605", dut.buffer[0]); end
    checks++; if (bus.route_reserved !== 2'b01) begin errors++; $display("[TB] FAIL ovf_grant_pulse got=%b exp=01", bus.route_reserved); end
    checks++; if (bus.head_ready !== 2'b11) begin errors++; $display("[TB] FAIL ovf_grant_ready got=%b exp=11", bus.head_ready); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got=%b exp=1", bus.overflow_err); end
    do_reset();
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_reset got=%b exp=0", bus.overflow_err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 100 == 99) do_reset();
      bus.phit_valid = ($urandom_range(0, 99) < 60);
      bus.phit_vc    = 1'($urandom_range(0, 1));
      bus.phit_data  = 8'($urandom);
      bus.req_grant  = ($urandom_range(0, 1) == 1);
      model_outputs();
      checks++; if (bus.head_ready !== e_ready) begin errors++; $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.head_ready, e_ready); end
      checks++; if (bus.req_valid !== e_valid) begin errors++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, bus.req_valid, e_valid); end
      if (e_valid) begin
        checks++; if (bus.req_vc !== 1'(e_vc)) begin errors++; $display("[TB] FAIL rand_vc cyc=%0d got=%b exp=%0d", cyc, bus.req_vc, e_vc); end
        checks++; if (bus.req_route !== e_route) begin errors++; $display("[TB] FAIL rand_route cyc=%0d got=%0d exp=%0d", cyc, bus.req_route, e_route); end
      end
      checks++; if (bus.route_reserved !== m_pulse) begin errors++; $display("[TB] FAIL rand_pulse cyc=%0d got=%b exp=%b", cyc, bus.route_reserved, m_pulse); end
      checks++; if (bus.overflow_err !== m_ovf) begin errors++; $display("[TB] FAIL rand_overflow cyc=%0d got=%b exp=%b", cyc, bus.overflow_err, m_ovf); end
      tick();
    end
    bus.phit_valid = 1'b0;
    bus.req_grant  = 1'b0;
  endtask

  initial begin
    bus.phit_valid = 1'b0;
    bus.phit_vc    = '0;
    bus.phit_data  = '0;
    bus.req_grant  = 1'b0;
    test_reset();
    test_basic_handshake();
    test_round_robin();
    test_lock();
    test_interleave();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
